ram_rr_arbiter: RTL and testbench
=================================

# ram_rr_arbiter

Round-robin arbiter that shares one single-port, synchronous-read RAM between two requesters. Each requester has a valid/ready request channel and a read-response channel. The block drives the RAM's clock-domain address, data and write-enable pins. It sits between the RAM (address registered on the clock edge, data out combinational from the registered address) and two client blocks. It adds a bounded-burst policy so that one requester cannot starve the other.

## Interface
- AWIDTH, 3: RAM address width; depth = 2**AWIDTH.
- DWIDTH, 32: RAM data width.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is waiting; legal range 1..15.
- clock  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  bit i = requester i presents a request.
- req_we  input  2  bit i = 1 means write, 0 means read.
- req_addr  input  2*AWIDTH  requester i address in slice [i*AWIDTH +: AWIDTH].
- req_wdata  input  2*DWIDTH  requester i write data in slice [i*DWIDTH +: DWIDTH].
- req_ready  output  2  one-hot or zero; bit i = requester i accepted this cycle.
- rsp_valid  output  2  bit i = read data for requester i is on rsp_rdata this cycle.
- rsp_rdata  output  DWIDTH  read data; equals ram_dout.
- ram_addr  output  AWIDTH  to RAM address pin.
- ram_din  output  DWIDTH  to RAM data-in pin.
- ram_we  output  1  to RAM write-enable pin.
- ram_dout  input  DWIDTH  from RAM data-out pin.

## Operation
- Transfer: req_valid[i] & req_ready[i] in the same cycle. At most one transfer per cycle.
- The grant is combinational from req_valid, the priority pointer and the burst counter.
  - ram_addr and ram_din are muxed from the granted requester.
  - ram_we = granted req_we. It is 0 when no grant exists.
  - With no grant, ram_addr and ram_din hold requester 0's values, and ram_we = 0.
- Priority pointer `last` (1 bit) holds the most recent winner.
  - With both requesters valid, requester ~last wins, unless the burst rule applies.
  - With one requester valid, it wins regardless of `last`.
- Burst rule: `burst_cnt` counts consecutive grants to `last`.
  - If both requesters are valid and burst_cnt < MAX_BURST, `last` keeps the grant.
  - Once burst_cnt reaches MAX_BURST, the grant goes to the other requester.
  - burst_cnt resets to 1 whenever the winner changes.
  - burst_cnt saturates at MAX_BURST while a requester runs uncontended.
- State machine, 2 states:
  - IDLE: no grant in the previous cycle.
  - BUSY: grant in the previous cycle.
  - IDLE to BUSY on any transfer; BUSY to IDLE on a cycle with no transfer.
  - The state only qualifies burst_cnt: entering from IDLE loads burst_cnt = 1.
- Read response: a read transfer by requester i sets rsp_valid[i] = 1 in the next cycle, with rsp_rdata = ram_dout. There is no backpressure on the response channel.
- Writes produce no response.
- Read-after-write: a read accepted the cycle after a write to the same address returns the newly written data, as the RAM array itself provides.
- Reset (rst_n low, at any time):
  - req_ready = 0, rsp_valid = 0, ram_we = 0.
  - last = 1, so requester 0 has priority first.
  - burst_cnt = 0, state = IDLE.
  - A transfer in flight when reset asserts is dropped; its response is never issued.

## Timing
- Request to RAM pins: 0 cycles (combinational).
- Read transfer at edge N: RAM latches the address at N, and rsp_valid is high during cycle N+1.
- Back-to-back transfers every cycle are allowed, including alternating requesters.
- The request channel never stalls on response state.
- Deassertion of rst_n is synchronous to clock in the system. The first grant is possible in the first cycle after deassertion.

## Structure
- Shared package: a 2-state enum type for IDLE/BUSY, and the burst-counter width localparam (4 bits).
- Optional sub-module `rr_pick2`: a combinational 2-way round-robin picker with burst override, taking valid, last and burst_expired and producing the grant.
- The RAM is instantiated outside this block.

## Test plan
- Reset, then only requester 0 writes 0xA5 to addr 2 and then reads addr 2. Expect ready[0] on both cycles, rsp_valid = 2'b01 one cycle after the read, rsp_rdata = 0xA5.
- Both requesters hold valid reads continuously, with MAX_BURST = 4. Expect the grant sequence 0,0,0,0,1,1,1,1,0…, never more than 4 consecutive grants to one requester.
- Requester 1 alone streams 10 reads to addrs 0..7,0,1. Expect ready[1] every cycle and rsp_valid[1] on every following cycle, with data matching the preloaded pattern including the address wrap.
- Requester 0 writes 0x1234 to addr 5 at cycle N, and requester 1 reads addr 5 at cycle N+1. Expect rsp_rdata = 0x1234 at N+2.
- Assert rst_n low in the cycle right after a read transfer. Expect rsp_valid = 0 throughout reset. After release, a simultaneous request from both requesters is granted to requester 0 first.

Source files
------------

// File: rtl/ram_rr_arbiter_pkg.sv
`default_nettype none
// ram_rr_arbiter_pkg: shared arbiter state type and burst-counter width.
// Revision: 1.0
package ram_rr_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int BURST_W = 4;

endpackage
`default_nettype wire

// File: rtl/ram_rr_arbiter_rr_pick2.sv
`default_nettype none
// rr_pick2: combinational 2-way round-robin picker with burst override.
// Revision: 1.0
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       burst_expired,
   output logic [1:0] grant
);

   logic winner;

   // Under contention the previous winner keeps the grant until its burst expires.
   always_comb begin
      grant  = 2'b00;
      winner = burst_expired ? ~last : last;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = winner ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ram_rr_arbiter: shares one synchronous-read RAM between two requesters, bounded bursts.
// Revision: 1.0
module ram_rr_arbiter
   import ram_rr_arbiter_pkg::*;
#(
   parameter int AWIDTH    = 3,
   parameter int DWIDTH    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_we,
   input  logic [2*AWIDTH-1:0] req_addr,
   input  logic [2*DWIDTH-1:0] req_wdata,
   output logic [1:0]          req_ready,
   output logic [1:0]          rsp_valid,
   output logic [DWIDTH-1:0]   rsp_rdata,
   output logic [AWIDTH-1:0]   ram_addr,
   output logic [DWIDTH-1:0]   ram_din,
   output logic                ram_we,
   input  logic [DWIDTH-1:0]   ram_dout
);

   localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic               last;
   logic               last_nxt;
   logic [BURST_W-1:0] burst_cnt;
   logic [BURST_W-1:0] burst_cnt_nxt;
   logic [1:0]         pick;
   logic [1:0]         grant;
   logic               burst_expired;
   logic               xfer;
   logic               winner;

   // Coming out of IDLE there is no burst to extend, so plain rotation decides.
   assign burst_expired = (state == IDLE) || (burst_cnt >= MAX_CNT);

   rr_pick2 u_pick (
      .valid         (req_valid),
      .last          (last),
      .burst_expired (burst_expired),
      .grant         (pick)
   );

   assign grant     = rst_n ? pick : 2'b00;
   assign xfer      = |grant;
   assign winner    = grant[1];
   assign req_ready = grant;

   assign ram_addr  = winner ? req_addr[AWIDTH +: AWIDTH]  : req_addr[0 +: AWIDTH];
   assign ram_din   = winner ? req_wdata[DWIDTH +: DWIDTH] : req_wdata[0 +: DWIDTH];
   assign ram_we    = xfer & (winner ? req_we[1] : req_we[0]);
   assign rsp_rdata = ram_dout;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
         rsp_valid <= 2'b00;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_cnt_nxt;
         rsp_valid <= grant & {2{~ram_we}};
      end
   end

   always_comb begin
      state_nxt     = state;
      last_nxt      = last;
      burst_cnt_nxt = burst_cnt;
      if (xfer) begin
         state_nxt = BUSY;
         last_nxt  = winner;
         if ((state == IDLE) || (winner != last)) begin
            burst_cnt_nxt = BURST_W'(1);
         end else if (burst_cnt < MAX_CNT) begin
            burst_cnt_nxt = burst_cnt + 1'b1;
         end
      end else begin
         state_nxt = IDLE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// tb_ram_rr_arbiter: directed and randomized checks of ram_rr_arbiter against a policy-level model.
// Revision: 1.0
module tb_ram_rr_arbiter;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clock = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]    req_ready;
   logic [1:0]    rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   ram_rr_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   // External RAM: registered address, combinational read from it.
   logic [DW-1:0] mem [8];
   logic [AW-1:0] addr_q;
   logic          load_en;

   function automatic logic [DW-1:0] pat(input int i);
      return 32'hC0DE_0000 | (32'(i) * 32'h111);
   endfunction

   always @(posedge clock) begin
      if (load_en) begin
         for (int i = 0; i < 8; i++) mem[i] <= pat(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      addr_q <= ram_addr;
   end
   assign ram_dout = mem[addr_q];

   // Reference model: who owns the current uninterrupted run of grants and how long it is.
   logic          m_last;
   int            m_streak;
   logic [DW-1:0] shadow [8];
   logic [1:0]    exp_rv;
   logic [DW-1:0] exp_rd;

   function automatic logic [1:0] model_grant(input logic [1:0] v);
      if (v == 2'b11) begin
         if (m_streak > 0 && m_streak < MB) return m_last ? 2'b10 : 2'b01;
         return m_last ? 2'b01 : 2'b10;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_last   = 1'b1;
      m_streak = 0;
      exp_rv   = 2'b00;
      exp_rd   = '0;
   endtask

   task automatic model_commit(input logic [1:0] g);
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      exp_rv = 2'b00;
      if (g != 2'b00) begin
         w = g[1];
         a = w ? req_addr[AW +: AW]  : req_addr[0 +: AW];
         d = w ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
         if (req_we[w]) begin
            shadow[a] = d;
         end else begin
            exp_rv = g;
            exp_rd = shadow[a];
         end
         if (m_streak > 0 && w == m_last) m_streak++;
         else m_streak = 1;
         m_last = w;
      end else begin
         m_streak = 0;
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      @(negedge clock);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_we    = 2'b00;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clock);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b11;
      #1;
      tests++;
      if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      tests++;
      if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      tests++;
      if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      apply_reset();
      drive(2'b00, 2'b00, 3'd3, 3'd6, 32'h11, 32'h22);
      tests++;
      if (req_ready !== 2'b00 || ram_we !== 1'b0) begin
         fails++; $display("FAIL idle_no_grant: ready %b we %b want 00 0", req_ready, ram_we);
      end
      tests++;
      if (ram_addr !== 3'd3 || ram_din !== 32'h11) begin
         fails++; $display("FAIL idle_pins_req0: addr %0d din %h want 3 00000011", ram_addr, ram_din);
      end
      model_commit(2'b00);
   endtask

   task automatic test_write_read();
      drive(2'b01, 2'b01, 3'd2, 3'd0, 32'hA5, 32'h0);
      tests++;
      if (req_ready !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 3'd2) begin
         fails++; $display("FAIL wr_accept: ready %b we %b addr %0d want 01 1 2", req_ready, ram_we, ram_addr);
      end
      model_commit(model_grant(req_valid));
      drive(2'b01, 2'b00, 3'd2, 3'd0, 32'h0, 32'h0);
      tests++;
      if (req_ready !== 2'b01 || ram_we !== 1'b0) begin
         fails++; $display("FAIL rd_accept: ready %b we %b want 01 0", req_ready, ram_we);
      end
      model_commit(model_grant(req_valid));
      drive(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hA5) begin
         fails++; $display("FAIL rd_resp: valid %b data %h want 01 000000a5", rsp_valid, rsp_rdata);
      end
      model_commit(2'b00);
   endtask

   task automatic test_burst();
      logic [11:0] seq;
      logic [1:0]  want;
      seq = 12'b0000_1111_0000;
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         drive(2'b11, 2'b00, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 32'h0, 32'h0);
         want = seq[11-i] ? 2'b10 : 2'b01;
         tests++;
         if (req_ready !== want) begin
            fails++; $display("FAIL burst_seq[%0d]: got %b want %b", i, req_ready, want);
         end
         tests++;
         if (rsp_valid !== exp_rv || (exp_rv != 2'b00 && rsp_rdata !== exp_rd)) begin
            fails++; $display("FAIL burst_rsp[%0d]: valid %b data %h want %b %h", i, rsp_valid, rsp_rdata, exp_rv, exp_rd);
         end
         model_commit(want);
      end
   endtask

   task automatic test_stream1();
      for (int i = 0; i < 11; i++) begin
         if (i < 10) drive(2'b10, 2'b00, 3'd0, 3'(i % 8), 32'h0, 32'h0);
         else drive(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
         tests++;
         if (req_ready !== ((i < 10) ? 2'b10 : 2'b00)) begin
            fails++; $display("FAIL stream_ready[%0d]: got %b", i, req_ready);
         end
         if (i > 0) begin
            tests++;
            if (rsp_valid !== 2'b10 || rsp_rdata !== shadow[(i - 1) % 8]) begin
               fails++; $display("FAIL stream_rsp[%0d]: valid %b data %h want 10 %h", i, rsp_valid, rsp_rdata, shadow[(i - 1) % 8]);
            end
         end
         model_commit(model_grant(req_valid));
      end
   endtask

   task automatic test_raw();
      drive(2'b01, 2'b01, 3'd5, 3'd0, 32'h1234, 32'h0);
      tests++;
      if (req_ready !== 2'b01) begin fails++; $display("FAIL raw_wr: got %b want 01", req_ready); end
      model_commit(model_grant(req_valid));
      drive(2'b10, 2'b00, 3'd0, 3'd5, 32'h0, 32'h0);
      tests++;
      if (req_ready !== 2'b10) begin fails++; $display("FAIL raw_rd: got %b want 10", req_ready); end
      model_commit(model_grant(req_valid));
      drive(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
      tests++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h1234) begin
         fails++; $display("FAIL raw_rsp: valid %b data %h want 10 00001234", rsp_valid, rsp_rdata);
      end
      model_commit(2'b00);
   endtask

   task automatic test_random();
      logic [1:0]    g;
      logic          w;
      logic [AW-1:0] a;
      for (int i = 0; i < 300; i++) begin
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom);
         g = model_grant(req_valid);
         w = g[1];
         a = w ? req_addr[AW +: AW] : req_addr[0 +: AW];
         tests++;
         if (req_ready !== g) begin
            fails++; $display("FAIL rand_ready[%0d]: got %b want %b (valid %b)", i, req_ready, g, req_valid);
         end
         tests++;
         if (ram_we !== (g != 2'b00 && req_we[w]) || ram_addr !== a) begin
            fails++; $display("FAIL rand_pins[%0d]: we %b addr %0d want %b %0d", i, ram_we, ram_addr, (g != 2'b00 && req_we[w]), a);
         end
         tests++;
         if (rsp_valid !== exp_rv || (exp_rv != 2'b00 && rsp_rdata !== exp_rd)) begin
            fails++; $display("FAIL rand_rsp[%0d]: valid %b data %h want %b %h", i, rsp_valid, rsp_rdata, exp_rv, exp_rd);
         end
         model_commit(g);
      end
   endtask

   task automatic test_reset_inflight();
      drive(2'b01, 2'b00, 3'd4, 3'd0, 32'h0, 32'h0);
      tests++;
      if (req_ready !== 2'b01) begin fails++; $display("FAIL inflight_rd: got %b want 01", req_ready); end
      model_commit(model_grant(req_valid));
      @(negedge clock);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {3'd7, 3'd1};
      #1;
      tests++;
      if (rsp_valid !== 2'b00) begin fails++; $display("FAIL inflight_drop: got %b want 00", rsp_valid); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1;
         tests++;
         if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            fails++; $display("FAIL inflight_hold[%0d]: valid %b ready %b want 00 00", i, rsp_valid, req_ready);
         end
      end
      model_reset();
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin fails++; $display("FAIL post_reset_prio: got %b want 01", req_ready); end
      model_commit(model_grant(req_valid));
      drive(2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== shadow[1]) begin
         fails++; $display("FAIL post_reset_rsp: valid %b data %h want 01 %h", rsp_valid, rsp_rdata, shadow[1]);
      end
      model_commit(2'b00);
   endtask

   initial begin
      rst_n     = 1'b0;
      load_en   = 1'b1;
      req_valid = 2'b00;
      req_we    = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < 8; i++) shadow[i] = pat(i);
      model_reset();
      repeat (2) @(negedge clock);
      load_en = 1'b0;
      test_reset();
      test_write_read();
      test_burst();
      test_stream1();
      test_raw();
      test_random();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
